// File: rtl/port2_rx_fifo_pkg.sv
// ----------------------------------------------------------------------------
// port2_rx_fifo_pkg
// Shared constants and types for the device port 2 receive buffer.
//   - default word width and bus addresses for the data and status registers
//   - bit positions of the flags inside the status byte
//   - read-decode selector enum and a status-byte packing helper
// ----------------------------------------------------------------------------
package port2_rx_fifo_pkg;

    localparam int unsigned P2_DATA_WIDTH  = 8;
    localparam logic [7:0]  P2_ADDR_DATA   = 8'hF0;
    localparam logic [7:0]  P2_ADDR_STATUS = 8'hF1;

    // Status byte layout: {overflow, full, empty, 1'b0, count[3:0]}
    localparam int unsigned P2_ST_OVF   = 7;
    localparam int unsigned P2_ST_FULL  = 6;
    localparam int unsigned P2_ST_EMPTY = 5;

    typedef enum logic [1:0] {
        RdNone,
        RdData,
        RdStatus
    } rd_sel_e;

    function automatic logic [7:0] pack_status(
        input logic       ovf,
        input logic       full,
        input logic       empty,
        input logic [3:0] cnt
    );
        logic [7:0] st;
        st              = '0;
        st[P2_ST_OVF]   = ovf;
        st[P2_ST_FULL]  = full;
        st[P2_ST_EMPTY] = empty;
        st[3:0]         = cnt;
        return st;
    endfunction

endpackage

// File: rtl/port2_rx_fifo_sync_fifo.sv
// ----------------------------------------------------------------------------
// port2_rx_fifo_sync_fifo
// Single-clock FIFO with a combinational head word. No overflow tracking:
// a push while full is ignored unless a pop happens in the same cycle.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_push, i_din  write request and word
//   i_pop          read request (ignored while empty)
//   o_dout         head word (valid when not empty)
//   o_count        number of stored words (0..DEPTH)
//   o_full/o_empty occupancy flags
// ----------------------------------------------------------------------------
module port2_rx_fifo_sync_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [DW-1:0]              i_din,
    output logic [DW-1:0]              o_dout,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    // A pop frees a slot on the same edge, so a full FIFO may still accept a push.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/port2_rx_fifo.sv
// ----------------------------------------------------------------------------
// port2_rx_fifo
// Receive buffer for device port 2. Words presented by an external device
// with an asynchronous strobe are synchronised, edge-detected and queued.
// The controller pops words or reads a status byte through two bus
// addresses; the registered output is zero unless this block was addressed,
// so it can sit on the data_bus daisy chain.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_dev_data        device word, stable while i_dev_strobe is high
//   i_dev_strobe      asynchronous strobe pin; each rising edge is one word
//   i_addr_bus, i_re  controller read address and read enable
//   o_data_bus_out    registered read data toward the data_bus node
//   o_irq             registered level interrupt (count >= IRQ_THRESH)
// ----------------------------------------------------------------------------
module port2_rx_fifo
    import port2_rx_fifo_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = P2_DATA_WIDTH,
    parameter int unsigned           DEPTH       = 8,
    parameter logic [DATA_WIDTH-1:0] ADDR_DATA   = DATA_WIDTH'(P2_ADDR_DATA),
    parameter logic [DATA_WIDTH-1:0] ADDR_STATUS = DATA_WIDTH'(P2_ADDR_STATUS),
    parameter int unsigned           IRQ_THRESH  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_dev_data,
    input  logic                  i_dev_strobe,
    input  logic [DATA_WIDTH-1:0] i_addr_bus,
    input  logic                  i_re,
    output logic [DATA_WIDTH-1:0] o_data_bus_out,
    output logic                  o_irq
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // Strobe synchroniser and edge detector
    logic r_sync1;
    logic r_sync2;
    logic r_sync3;
    logic w_strobe_rise;

    // Captured word waiting to enter the FIFO
    logic                  r_push;
    logic [DATA_WIDTH-1:0] r_push_data;

    logic                  r_ovf;
    logic                  r_irq;
    logic [DATA_WIDTH-1:0] r_data_bus_out;

    logic [DATA_WIDTH-1:0] w_head;
    logic [CW-1:0]         w_count;
    logic [CW-1:0]         w_count_next;
    logic                  w_full;
    logic                  w_empty;
    rd_sel_e               w_rd_sel;
    logic                  w_pop_req;
    logic                  w_do_pop;
    logic                  w_do_push;
    logic                  w_ovf_evt;
    logic                  w_ovf_next;
    logic                  w_irq_next;
    logic [7:0]            w_status;
    logic [DATA_WIDTH-1:0] w_dout_next;

    assign w_strobe_rise = r_sync2 & ~r_sync3;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync3     <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_sync1     <= i_dev_strobe;
            r_sync2     <= r_sync1;
            r_sync3     <= r_sync2;
            r_push      <= w_strobe_rise;
            if (w_strobe_rise) begin
                r_push_data <= i_dev_data;
            end
        end
    end

    always_comb begin
        w_rd_sel = RdNone;
        if (i_re) begin
            if (i_addr_bus == ADDR_DATA) begin
                w_rd_sel = RdData;
            end else if (i_addr_bus == ADDR_STATUS) begin
                w_rd_sel = RdStatus;
            end
        end
    end

    assign w_pop_req = (w_rd_sel == RdData);
    assign w_do_pop  = w_pop_req & ~w_empty;
    // A full FIFO still takes the push when a pop frees a slot on the same edge.
    assign w_do_push = r_push & (~w_full | w_do_pop);
    assign w_ovf_evt = r_push & w_full & ~w_pop_req;

    assign w_count_next = w_count + CW'(w_do_push) - CW'(w_do_pop);
    assign w_status     = pack_status(r_ovf, w_full, w_empty, 4'(w_count));

    always_comb begin
        w_dout_next = '0;
        unique case (w_rd_sel)
            RdData:   w_dout_next = w_empty ? '0 : w_head;
            RdStatus: w_dout_next = DATA_WIDTH'(w_status);
            default:  w_dout_next = '0;
        endcase
    end

    // A status read clears overflow, but a fresh overflow on the same edge wins.
    assign w_ovf_next = (r_ovf & (w_rd_sel != RdStatus)) | w_ovf_evt;
    assign w_irq_next = (32'(w_count_next) >= IRQ_THRESH);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf          <= 1'b0;
            r_irq          <= 1'b0;
            r_data_bus_out <= '0;
        end else begin
            r_ovf          <= w_ovf_next;
            r_irq          <= w_irq_next;
            r_data_bus_out <= w_dout_next;
        end
    end

    assign o_data_bus_out = r_data_bus_out;
    assign o_irq          = r_irq;

    port2_rx_fifo_sync_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_do_push),
        .i_pop   (w_do_pop),
        .i_din   (r_push_data),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_port2_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_port2_rx_fifo
// Directed scenarios followed by randomized traffic, all compared every cycle
// against a queue-based reference model of the receive buffer.
// ----------------------------------------------------------------------------
module tb_port2_rx_fifo;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned THRESH = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dev_data;
    logic       strobe;
    logic [7:0] addr_bus;
    logic       re;
    logic [7:0] dout;
    logic       irq;

    always #5 clk = ~clk;

    port2_rx_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (DEPTH),
        .IRQ_THRESH (THRESH)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_dev_data     (dev_data),
        .i_dev_strobe   (strobe),
        .i_addr_bus     (addr_bus),
        .i_re           (re),
        .o_data_bus_out (dout),
        .o_irq          (irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         due;
        logic [7:0] data;
    } pend_t;

    logic [7:0] mq[$];
    pend_t      pend[$];
    bit         m_ovf;
    bit         m_prev_pin;
    int         ecnt;
    logic [7:0] exp_dout;
    logic       exp_irq;

    // Called right after each rising edge with the inputs that edge sampled.
    task automatic model_edge();
        bit         is_push;
        bit         ovf_evt;
        logic [7:0] wd;
        logic [7:0] st;
        bit         pop_req;
        bit         st_req;
        ecnt++;
        if (rst) begin
            mq.delete();
            pend.delete();
            m_ovf      = 1'b0;
            m_prev_pin = 1'b0;
            exp_dout   = 8'h00;
            exp_irq    = 1'b0;
            return;
        end
        is_push = 1'b0;
        wd      = 8'h00;
        if (pend.size() > 0 && pend[0].due == ecnt) begin
            is_push = 1'b1;
            wd      = pend[0].data;
            void'(pend.pop_front());
        end
        // Pin first seen high at this edge: the word lands three edges later.
        if (strobe && !m_prev_pin) begin
            pend.push_back('{due: ecnt + 3, data: dev_data});
        end
        m_prev_pin = strobe;

        pop_req = re && (addr_bus == 8'hF0);
        st_req  = re && (addr_bus == 8'hF1);
        st = {m_ovf, (mq.size() == DEPTH), (mq.size() == 0), 1'b0, 4'(mq.size())};

        exp_dout = 8'h00;
        if (pop_req) begin
            if (mq.size() > 0) exp_dout = mq.pop_front();
        end else if (st_req) begin
            exp_dout = st;
        end

        ovf_evt = 1'b0;
        if (is_push) begin
            if (mq.size() < DEPTH) mq.push_back(wd);
            else                   ovf_evt = 1'b1;
        end
        if (st_req)  m_ovf = 1'b0;
        if (ovf_evt) m_ovf = 1'b1;
        exp_irq = (mq.size() >= THRESH);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("dout", {24'h0, dout}, {24'h0, exp_dout});
        check_eq("irq", {31'h0, irq}, {31'h0, exp_irq});
    endtask

    task automatic strobe_word(input logic [7:0] d);
        dev_data = d;
        strobe   = 1'b1;
        step();
        step();
        step();
        strobe = 1'b0;
        step();
        step();
    endtask

    task automatic rd_expect(input logic [7:0] a, input logic [7:0] exp, input string tag);
        re       = 1'b1;
        addr_bus = a;
        step();
        check_eq(tag, {24'h0, dout}, {24'h0, exp});
        re       = 1'b0;
        addr_bus = 8'h00;
    endtask

    initial begin
        int hi_left;
        int lo_left;
        int rate;

        rst        = 1'b1;
        dev_data   = 8'h00;
        strobe     = 1'b0;
        addr_bus   = 8'h00;
        re         = 1'b0;
        m_ovf      = 1'b0;
        m_prev_pin = 1'b0;
        ecnt       = 0;
        exp_dout   = 8'h00;
        exp_irq    = 1'b0;

        // 1. Reset with the strobe toggling
        dev_data = 8'h3C;
        strobe   = 1'b1;
        step();
        strobe = 1'b0;
        step();
        strobe = 1'b1;
        step();
        strobe = 1'b0;
        rst    = 1'b0;
        step();
        check_eq("rst_dout", {24'h0, dout}, 32'h0);
        check_eq("rst_irq", {31'h0, irq}, 32'h0);
        repeat (4) step();
        rd_expect(8'hF1, 8'h20, "rst_status");

        // 2. Single word
        strobe_word(8'hA5);
        check_eq("single_irq", {31'h0, irq}, 32'h1);
        rd_expect(8'hF0, 8'hA5, "single_pop");
        rd_expect(8'hF1, 8'h20, "single_status");
        check_eq("single_irq_clr", {31'h0, irq}, 32'h0);

        // 3. Fill and overflow
        for (int i = 1; i <= 9; i++) strobe_word(8'(i));
        rd_expect(8'hF1, 8'hC8, "ovf_status");
        rd_expect(8'hF1, 8'h48, "ovf_status_clr");
        for (int i = 1; i <= 8; i++) rd_expect(8'hF0, 8'(i), "ovf_pop");
        rd_expect(8'hF0, 8'h00, "empty_pop");
        rd_expect(8'hF1, 8'h20, "drained_status");

        // 4. Full with push and pop on the same edge
        for (int i = 0; i < 8; i++) strobe_word(8'h10 + 8'(i));
        dev_data = 8'h18;
        strobe   = 1'b1;
        step();
        step();
        step();
        strobe   = 1'b0;
        re       = 1'b1;
        addr_bus = 8'hF0;
        step();
        check_eq("full_pp_pop", {24'h0, dout}, 32'h10);
        re       = 1'b0;
        addr_bus = 8'h00;
        step();
        rd_expect(8'hF1, 8'h48, "full_pp_status");
        for (int i = 1; i <= 8; i++) rd_expect(8'hF0, 8'h10 + 8'(i), "full_pp_drain");

        // 5. Wrap-around
        for (int i = 0; i < 20; i++) begin
            strobe_word(8'h40 + 8'(i));
            rd_expect(8'hF1, 8'h01, "wrap_status");
            rd_expect(8'hF0, 8'h40 + 8'(i), "wrap_pop");
        end

        // 6. Decode and reset mid-stream
        strobe_word(8'h71);
        strobe_word(8'h72);
        strobe_word(8'h73);
        rd_expect(8'hF2, 8'h00, "dec_f2");
        re       = 1'b0;
        addr_bus = 8'hF0;
        step();
        check_eq("dec_re0", {24'h0, dout}, 32'h0);
        addr_bus = 8'h00;
        rd_expect(8'hF1, 8'h03, "dec_status");
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        rd_expect(8'hF1, 8'h20, "mid_rst_status");

        // Randomized traffic
        hi_left = 0;
        lo_left = 2;
        for (int c = 0; c < 3000; c++) begin
            rate = (c < 1500) ? 2 : 6;
            rst  = ($urandom_range(0, 299) == 0);
            if (strobe) begin
                if (hi_left > 0) hi_left--;
                if (hi_left == 0) begin
                    strobe  = 1'b0;
                    lo_left = int'($urandom_range(1, 4));
                end
            end else if (lo_left > 0) begin
                lo_left--;
            end else if ($urandom_range(0, 2) == 0) begin
                strobe   = 1'b1;
                dev_data = 8'($urandom);
                hi_left  = int'($urandom_range(3, 6));
            end
            re = ($urandom_range(0, 9) < rate);
            case ($urandom_range(0, 3))
                0, 1:    addr_bus = 8'hF0;
                2:       addr_bus = 8'hF1;
                default: addr_bus = 8'($urandom);
            endcase
            step();
        end
        rst    = 1'b0;
        re     = 1'b0;
        strobe = 1'b0;
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
